sort_engine: RTL

Sequential bubble-sort engine that sits directly downstream of the team's `Comparer` block. It holds N 32-bit words in an internal register array and consumes the comparator's `ur`/`sr` flag buses to decide swaps. It performs one compare-and-optional-swap per cycle until the array is ordered. Data are loaded and read back through a simple addressed port, so the block serves as the sort datapath in the lab CPU's peripheral space.

---
 rtl/sort_pkg.sv | 17 +
 rtl/sort_engine_if.sv | 28 ++
 rtl/Comparer.sv | 12 +
 rtl/sort_engine.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared types and widths for the bubble-sort engine.
package sort_pkg;

    localparam int DW = 32;
    localparam int CW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + CW'(1);
    endfunction

endpackage

// File: rtl/sort_engine_if.sv
// Load/read/control port of sort_engine; master drives, slave (the engine) responds.
interface sort_engine_if #(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
);
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [sort_pkg::DW-1:0] wr_data;
    logic [AW-1:0]           rd_addr;
    logic [sort_pkg::DW-1:0] rd_data;
    logic                    start;
    logic                    signed_sel;
    logic                    descend;
    logic                    busy;
    logic                    done;
    logic [sort_pkg::CW-1:0] cmp_cnt;
    logic [sort_pkg::CW-1:0] swp_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, start, signed_sel, descend,
        input  rd_data, busy, done, cmp_cnt, swp_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, start, signed_sel, descend,
        output rd_data, busy, done, cmp_cnt, swp_cnt
    );
endinterface

// File: rtl/Comparer.sv
// Magnitude comparator: flag buses {lt, ne, gt} of a versus b, unsigned (ur) and signed (sr).
module Comparer #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [2:0]    ur,
    output logic [2:0]    sr
);
    assign ur = {a < b, a != b, a > b};
    assign sr = {$signed(a) < $signed(b), a != b, $signed(a) > $signed(b)};
endmodule

// File: rtl/sort_engine.sv
// Sequential bubble sort over N words, one compare-and-swap per cycle.
// Optional SORT_EARLY_EXIT_EN: stop as soon as a full pass makes no swap.
module sort_engine
    import sort_pkg::*;
#(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input logic          clk,
    input logic          rst,
    sort_engine_if.slave bus
);
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 2);

    state_t          state_q, state_d;
    logic [DW-1:0]   mem_q [N];
    logic [DW-1:0]   mem_d [N];
    logic [AW-1:0]   p_q, p_d;
    logic [AW-1:0]   j_q, j_d;
    logic            sgn_q, sgn_d;
    logic            desc_q, desc_d;
    logic [CW-1:0]   cmp_cnt_q, cmp_cnt_d;
    logic [CW-1:0]   swp_cnt_q, swp_cnt_d;
`ifdef SORT_EARLY_EXIT_EN
    logic            swapped_q, swapped_d;
`endif

    logic [AW-1:0]   j_hi;
    logic [DW-1:0]   cmp_a, cmp_b;
    logic [2:0]      ur, sr, flags;
    logic            do_swap, pass_end, sort_end;

    assign j_hi  = j_q + AW'(1);
    assign cmp_a = mem_q[j_q];
    assign cmp_b = mem_q[j_hi];

    Comparer #(.DW(DW)) u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .ur (ur),
        .sr (sr)
    );

    // ne qualifies both directions so equal words never move (stability).
    always_comb begin
        flags   = sgn_q ? sr : ur;
        do_swap = flags[1] & (desc_q ? flags[2] : flags[0]);
    end

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        j_d       = j_q;
        sgn_d     = sgn_q;
        desc_d    = desc_q;
        cmp_cnt_d = cmp_cnt_q;
        swp_cnt_d = swp_cnt_q;
        for (int i = 0; i < N; i++) mem_d[i] = mem_q[i];
`ifdef SORT_EARLY_EXIT_EN
        swapped_d = swapped_q;
`endif
        pass_end  = (j_q == LAST_IDX - p_q);
        sort_end  = 1'b0;

        case (state_q)
            IDLE: begin
                // Write first so a same-cycle start sorts the new value.
                if (bus.wr_en) mem_d[bus.wr_addr] = bus.wr_data;
                if (bus.start) begin
                    sgn_d     = bus.signed_sel;
                    desc_d    = bus.descend;
                    cmp_cnt_d = '0;
                    swp_cnt_d = '0;
                    p_d       = '0;
                    j_d       = '0;
`ifdef SORT_EARLY_EXIT_EN
                    swapped_d = 1'b0;
`endif
                    state_d   = CMP;
                end
            end
            CMP: begin
                cmp_cnt_d = sat_inc(cmp_cnt_q);
                if (do_swap) begin
                    mem_d[j_q]  = cmp_b;
                    mem_d[j_hi] = cmp_a;
                    swp_cnt_d   = sat_inc(swp_cnt_q);
                end
`ifdef SORT_EARLY_EXIT_EN
                swapped_d = swapped_q | do_swap;
`endif
                if (pass_end) begin
                    sort_end = (p_q == LAST_IDX);
`ifdef SORT_EARLY_EXIT_EN
                    sort_end = sort_end | ~(swapped_q | do_swap);
                    swapped_d = 1'b0;
`endif
                    if (sort_end) begin
                        state_d = DONE;
                    end else begin
                        p_d = p_q + AW'(1);
                        j_d = '0;
                    end
                end else begin
                    j_d = j_hi;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            p_q       <= '0;
            j_q       <= '0;
            sgn_q     <= 1'b0;
            desc_q    <= 1'b0;
            cmp_cnt_q <= '0;
            swp_cnt_q <= '0;
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
`ifdef SORT_EARLY_EXIT_EN
            swapped_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            j_q       <= j_d;
            sgn_q     <= sgn_d;
            desc_q    <= desc_d;
            cmp_cnt_q <= cmp_cnt_d;
            swp_cnt_q <= swp_cnt_d;
            for (int i = 0; i < N; i++) mem_q[i] <= mem_d[i];
`ifdef SORT_EARLY_EXIT_EN
            swapped_q <= swapped_d;
`endif
        end
    end

    assign bus.rd_data = mem_q[bus.rd_addr];
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == DONE);
    assign bus.cmp_cnt = cmp_cnt_q;
    assign bus.swp_cnt = swp_cnt_q;

endmodule
